// File: rtl/sync_fpd.sv
// Sequential binary32 divider: restoring division on the 24-bit significands,
// one quotient bit per cycle, truncating rounding, flush-to-zero on underflow.
module sync_fpd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient
);

    typedef enum logic [1:0] {IDLE, CALC, NORM, SPEC} state_t;

    state_t             state_q;
    logic [24:0]        rem_q, q_q;
    logic [23:0]        mb_q;
    logic [4:0]         cnt_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [31:0]        spec_q, quot_q;
    logic               done_q;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign_d;
    logic        is_spec_d;
    logic [31:0] spec_d;

    assign ea     = A[30:23];
    assign eb     = B[30:23];
    assign fa     = A[22:0];
    assign fb     = B[22:0];
    assign sign_d = A[31] ^ B[31];
    assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    // Subnormal inputs count as zero.
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);

    always_comb begin
        is_spec_d = 1'b1;
        spec_d    = 32'h7FC00000;
        if (nan_a || nan_b)
            spec_d = 32'h7FC00000;
        else if ((zero_a && zero_b) || (inf_a && inf_b))
            spec_d = 32'h7FC00000;
        else if (inf_a || zero_b)
            spec_d = {sign_d, 8'hFF, 23'd0};
        else if (zero_a || inf_b)
            spec_d = {sign_d, 31'd0};
        else
            is_spec_d = 1'b0;
    end

    logic        ge_d;
    logic [24:0] rem_sub_d, rem_d;

    assign ge_d      = rem_q >= {1'b0, mb_q};
    assign rem_sub_d = ge_d ? (rem_q - {1'b0, mb_q}) : rem_q;
    assign rem_d     = {rem_sub_d[23:0], 1'b0};

    logic signed [9:0] exp_adj_d;
    logic [22:0]       frac_d;
    logic [31:0]       norm_d;

    // q_q[24] is the integer bit; when clear the quotient is < 1 and shifts up one.
    always_comb begin
        exp_adj_d = q_q[24] ? exp_q : (exp_q - 10'sd1);
        frac_d    = q_q[24] ? q_q[23:1] : q_q[22:0];
        if (exp_adj_d >= 10'sd255)
            norm_d = {sign_q, 8'hFF, 23'd0};
        else if (exp_adj_d <= 10'sd0)
            norm_d = {sign_q, 31'd0};
        else
            norm_d = {sign_q, exp_adj_d[7:0], frac_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            spec_q  <= '0;
            quot_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    sign_q <= sign_d;
                    spec_q <= spec_d;
                    exp_q  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                    rem_q  <= {2'b01, fa};
                    mb_q   <= {1'b1, fb};
                    q_q    <= '0;
                    cnt_q  <= '0;
                    state_q <= is_spec_d ? SPEC : CALC;
                end
                CALC: begin
                    rem_q <= rem_d;
                    q_q   <= {q_q[23:0], ge_d};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd24)
                        state_q <= NORM;
                end
                NORM: begin
                    quot_q  <= norm_d;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                SPEC: begin
                    quot_q  <= spec_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign quotient = quot_q;

endmodule

// File: doc/sync_fpd.md
SYNC_FPD -- requirements
Module: sync_fpd

Interface
REQ-001 The block SHALL have no parameters; the format is fixed IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request pulse; A and B are sampled on the edge where start=1 and busy=0.
REQ-005 A  input  32  dividend, binary32.
REQ-006 B  input  32  divisor, binary32.
REQ-007 busy  output  1  high while a division is in progress; start is ignored while high.
REQ-008 done  output  1  one-cycle pulse; quotient is valid from this cycle onward.
REQ-009 quotient  output  32  A/B, binary32; held until the next done.

Function
REQ-010 Operation: divides A by B, one quotient bit per cycle, using restoring division on the 24-bit significands (hidden 1 restored).
REQ-011 FSM states and transitions:
- IDLE -> CALC on accepted start, normal operands.
- IDLE -> SPEC on accepted start, special operands.
- CALC -> NORM after 25 iterations.
- NORM -> IDLE.
- SPEC -> IDLE.
REQ-012 busy SHALL be 1 exactly in CALC, NORM and SPEC.
REQ-013 Normal-case timing (start accepted at edge E0):
- Iterations occur on edges E1..E25.
- quotient is updated and done=1 on edge E26.
- done clears on edge E27.
REQ-014 Special-case timing: quotient is updated and done=1 on edge E1.
REQ-015 A start sampled in the same cycle that done=1 SHALL be accepted, giving back-to-back operation.
REQ-016 Sign: A[31] XOR B[31] for all results except NaN.
REQ-017 Exponent: computed in 10-bit signed arithmetic as eA - eB + 127, minus 1 when the significand quotient is < 1.
REQ-018 Normalization: when the significand quotient is < 1, it is left-shifted 1 so that 24 significant bits remain.
REQ-019 Rounding: round toward zero (truncate); no guard, round or sticky bits are kept.
REQ-020 Overflow: an exponent >= 255 gives signed infinity (exp 0xFF, mantissa 0).
REQ-021 Underflow: an exponent <= 0 gives signed zero (flush to zero).
REQ-022 Input subnormals (exp=0, any mantissa) are treated as zero.
REQ-023 Special-case results, in priority order:
- A or B NaN -> 0x7FC00000.
- 0/0 or inf/inf -> 0x7FC00000.
- inf/x -> signed inf.
- x/0 -> signed inf.
- 0/x or x/inf -> signed zero.
REQ-024 done SHALL never be asserted without a preceding accepted start.
REQ-025 start=1 while busy=1 SHALL have no effect on state, operands or outputs.

Reset
REQ-026 When rst=1 at a clock edge: state <- IDLE, busy=0, done=0, quotient=0x00000000, internal remainder/counter cleared.
REQ-027 Reset SHALL override start and any operation in progress, which is aborted with no done.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-029 A=0xC1DA4000 (-27.28125), B=0xC0100000 (-2.25) -> quotient=0x41420000, done exactly 26 edges after the start edge, busy high for 26 cycles.
REQ-030 A=0x43130400 (147.015625), B=0x41420000 (12.125), issued in the done cycle of REQ-029 -> accepted, quotient=0x41420000.
REQ-031 A=0x3F800000, B=0x40400000 (1/3) -> quotient=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
REQ-032 Special cases, each with done on edge E1:
- A=0x40A40000, B=0 -> 0x7F800000.
- A=0, B=0x41420000 -> 0x00000000.
- A=0, B=0 -> 0x7FC00000.
- A=0xC0A40000, B=0x7F800000 -> 0x80000000.
REQ-033 A=0x7F000000, B=0x3E800000 -> overflow, 0x7F800000.
REQ-034 Reset mid-operation:
- rst=1 at edge E10 of a division -> busy=0, done=0, quotient=0, no done follows.
- A new start A=0x3F800000, B=0x3F800000 -> 0x3F800000.
- start pulses while busy -> ignored, result unchanged.
